// File: rtl/wb_unit_pkg.sv
// Shared types and constants for the write-back stage and register scoreboard.
package wb_unit_pkg;

  localparam int unsigned NREG = 16;
  localparam int unsigned DW   = 16;
  localparam int unsigned CNTW = 2;
  localparam int unsigned AW   = $clog2(NREG);

  localparam logic [1:0] RW_NONE = 2'b00;
  localparam logic [1:0] RW_DEST = 2'b01;
  localparam logic [1:0] RW_R0   = 2'b10;
  localparam logic [1:0] RW_BOTH = 2'b11;

  localparam logic [AW-1:0]   R0_IDX  = '0;
  localparam logic [CNTW-1:0] CNT_MAX = '1;

  // Contents of the write-back register
  typedef struct packed {
    logic [1:0]    code;
    logic [AW-1:0] dest;
    logic [DW-1:0] data;
    logic [DW-1:0] r0;
  } wb_t;

  // Register r belongs to the write set of (dest, code); R0 is counted once for code 11 with dest 0
  function automatic logic in_set(input logic [AW-1:0] r, input logic [AW-1:0] dest,
                                  input logic [1:0] code);
    return (code[0] && (dest == r)) || (code[1] && (r == R0_IDX));
  endfunction

endpackage

// File: rtl/wb_unit_if.sv
// Issue, MEM, register-file and operand-lookup signals of the write-back unit.
interface wb_unit_if;
  import wb_unit_pkg::*;

  logic          in_issue_valid;
  logic [AW-1:0] in_issue_dest;
  logic [1:0]    in_issue_regwrite;
  logic          out_issue_full;
  logic          in_mem_valid;
  logic [AW-1:0] in_mem_dest;
  logic [1:0]    in_mem_regwrite;
  logic          in_mem_memtoreg;
  logic [DW-1:0] in_alu_result;
  logic [DW-1:0] in_load_data;
  logic [DW-1:0] in_rem;
  logic [DW-1:0] out_data;
  logic [AW-1:0] out_wr_addr;
  logic [DW-1:0] out_r0;
  logic [1:0]    out_cntrl_regwrite;
  logic [AW-1:0] in_op1_addr;
  logic [AW-1:0] in_op2_addr;
  logic          out_op1_busy;
  logic          out_op2_busy;
  logic          out_op1_fwd;
  logic          out_op2_fwd;
  logic [DW-1:0] out_fwd_data1;
  logic [DW-1:0] out_fwd_data2;
  logic          out_sb_err;

  modport master (
    output in_issue_valid, in_issue_dest, in_issue_regwrite,
    output in_mem_valid, in_mem_dest, in_mem_regwrite, in_mem_memtoreg,
    output in_alu_result, in_load_data, in_rem, in_op1_addr, in_op2_addr,
    input  out_issue_full, out_data, out_wr_addr, out_r0, out_cntrl_regwrite,
    input  out_op1_busy, out_op2_busy, out_op1_fwd, out_op2_fwd,
    input  out_fwd_data1, out_fwd_data2, out_sb_err
  );

  modport slave (
    input  in_issue_valid, in_issue_dest, in_issue_regwrite,
    input  in_mem_valid, in_mem_dest, in_mem_regwrite, in_mem_memtoreg,
    input  in_alu_result, in_load_data, in_rem, in_op1_addr, in_op2_addr,
    output out_issue_full, out_data, out_wr_addr, out_r0, out_cntrl_regwrite,
    output out_op1_busy, out_op2_busy, out_op1_fwd, out_op2_fwd,
    output out_fwd_data1, out_fwd_data2, out_sb_err
  );

endinterface

// File: rtl/wb_unit_sb_counter.sv
// One pending-write counter: saturates at both ends and flags the attempt.
module sb_counter
  import wb_unit_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            inc,
  input  logic            dec,
  output logic [CNTW-1:0] cnt,
  output logic            err_c
);

  // Flag an increment at max or a decrement at zero
  always_comb begin
    err_c = 1'b0;
    if (inc && !dec && (cnt == CNT_MAX)) err_c = 1'b1;
    if (dec && !inc && (cnt == '0))      err_c = 1'b1;
  end

  // Counter update; inc and dec together cancel
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (inc && !dec && (cnt != CNT_MAX)) begin
      cnt <= cnt + CNTW'(1);
    end else if (dec && !inc && (cnt != '0)) begin
      cnt <= cnt - CNTW'(1);
    end
  end

endmodule

// File: rtl/wb_unit.sv
// Write-back register, register-file write port and per-register pending-write scoreboard.
module wb_unit
  import wb_unit_pkg::*;
(
  input  logic     CLOCK,
  input  logic     in_rst,
  wb_unit_if.slave bus
);

  wb_t             wb;
  logic            sb_err;
  logic            full;
  logic [NREG-1:0] iss;
  logic [NREG-1:0] sat;
  logic [NREG-1:0] inc;
  logic [NREG-1:0] dec;
  logic [NREG-1:0] err;
  logic [CNTW-1:0] cnt [NREG];

  // Issue and retire write sets, and which counters are already full
  always_comb begin
    iss = '0;
    dec = '0;
    sat = '0;
    for (int unsigned i = 0; i < NREG; i++) begin
      iss[i] = bus.in_issue_valid && in_set(AW'(i), bus.in_issue_dest, bus.in_issue_regwrite);
      dec[i] = in_set(AW'(i), wb.dest, wb.code);
      sat[i] = (cnt[i] == CNT_MAX);
    end
  end

  // A retiring register frees its slot in the same cycle, so it never blocks issue
  assign full = |(iss & sat & ~dec);
  assign inc  = full ? '0 : iss;

  for (genvar g = 0; g < int'(NREG); g++) begin : g_cnt
    sb_counter u_cnt (
      .clk   (CLOCK),
      .rst   (in_rst),
      .inc   (inc[g]),
      .dec   (dec[g]),
      .cnt   (cnt[g]),
      .err_c (err[g])
    );
  end

  // WB register: capture a writing MEM result, otherwise drop the write and hold data
  always_ff @(posedge CLOCK) begin
    if (in_rst) begin
      wb <= '0;
    end else if (bus.in_mem_valid && (bus.in_mem_regwrite != RW_NONE)) begin
      wb <= '{code: bus.in_mem_regwrite,
              dest: bus.in_mem_dest,
              data: bus.in_mem_memtoreg ? bus.in_load_data : bus.in_alu_result,
              r0:   bus.in_rem};
    end else begin
      wb.code <= RW_NONE;
    end
  end

  // Sticky scoreboard error
  always_ff @(posedge CLOCK) begin
    if (in_rst) begin
      sb_err <= 1'b0;
    end else if (|err) begin
      sb_err <= 1'b1;
    end
  end

  // Operand lookup: busy when pending, forward when the only pending write is in WB now
  always_comb begin
    bus.out_op1_busy  = (cnt[bus.in_op1_addr] != '0);
    bus.out_op2_busy  = (cnt[bus.in_op2_addr] != '0);
    bus.out_op1_fwd   = (cnt[bus.in_op1_addr] == CNTW'(1)) && in_set(bus.in_op1_addr, wb.dest, wb.code);
    bus.out_op2_fwd   = (cnt[bus.in_op2_addr] == CNTW'(1)) && in_set(bus.in_op2_addr, wb.dest, wb.code);
    bus.out_fwd_data1 = ((bus.in_op1_addr == R0_IDX) && wb.code[1]) ? wb.r0 : wb.data;
    bus.out_fwd_data2 = ((bus.in_op2_addr == R0_IDX) && wb.code[1]) ? wb.r0 : wb.data;
  end

  assign bus.out_issue_full     = full;
  assign bus.out_data           = wb.data;
  assign bus.out_wr_addr        = wb.dest;
  assign bus.out_r0             = wb.r0;
  assign bus.out_cntrl_regwrite = wb.code;
  assign bus.out_sb_err         = sb_err;

endmodule

// File: tb/tb_wb_unit.sv
// Scoreboard bench for wb_unit: directed scenarios then constrained-random traffic.
module tb_wb_unit;

  typedef struct {
    bit          rst;
    bit          iv;
    int          idest;
    int          icode;
    bit          mv;
    int          mdest;
    int          mcode;
    bit          mtr;
    logic [15:0] alu;
    logic [15:0] ld;
    logic [15:0] rem;
    int          a1;
    int          a2;
  } stim_t;

  typedef struct {
    int          cyc;
    logic [1:0]  code;
    logic [3:0]  dest;
    logic [15:0] data;
    logic [15:0] r0;
  } wb_exp_t;

  typedef struct {
    logic        full, b1, b2, f1, f2, err;
    logic [15:0] d1, d2;
    logic [1:0]  code;
    logic [3:0]  dest;
    logic [15:0] data, r0;
  } comb_exp_t;

  typedef struct {
    int dest;
    int code;
  } ifl_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_err = 0;

  wb_unit_if bus ();

  wb_unit dut (
    .CLOCK  (clk),
    .in_rst (rst),
    .bus    (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference model state: outstanding writes per register and the WB slot contents
  int          pend [16];
  bit          m_err;
  logic [1:0]  m_code;
  logic [3:0]  m_dest;
  logic [15:0] m_data, m_r0;

  wb_exp_t   wq[$];
  comb_exp_t cq[$];
  ifl_t      inflight[$];

  // Registers written by an instruction with this destination and regwrite code
  function automatic bit touches(int r, int dest, int code);
    bit d_hit = ((code == 1) || (code == 3)) && (r == dest);
    bit r_hit = (code >= 2) && (r == 0);
    return d_hit || r_hit;
  endfunction

  function automatic stim_t idle();
    stim_t s;
    s = '{default: 0};
    return s;
  endfunction

  // Drive one cycle of stimulus, record expectations, advance the model past the next edge
  task automatic step(input stim_t s);
    comb_exp_t ce;
    wb_exp_t   we;
    bit        acc;
    int        n;
    rst                   = s.rst;
    bus.in_issue_valid    = s.iv;
    bus.in_issue_dest     = 4'(s.idest);
    bus.in_issue_regwrite = 2'(s.icode);
    bus.in_mem_valid      = s.mv;
    bus.in_mem_dest       = 4'(s.mdest);
    bus.in_mem_regwrite   = 2'(s.mcode);
    bus.in_mem_memtoreg   = s.mtr;
    bus.in_alu_result     = s.alu;
    bus.in_load_data      = s.ld;
    bus.in_rem            = s.rem;
    bus.in_op1_addr       = 4'(s.a1);
    bus.in_op2_addr       = 4'(s.a2);
    #1;
    ce.full = 1'b0;
    for (int r = 0; r < 16; r++)
      if (s.iv && touches(r, s.idest, s.icode) && pend[r] == 3 && !touches(r, m_dest, m_code))
        ce.full = 1'b1;
    ce.b1   = pend[s.a1] != 0;
    ce.b2   = pend[s.a2] != 0;
    ce.f1   = pend[s.a1] == 1 && touches(s.a1, m_dest, m_code);
    ce.f2   = pend[s.a2] == 1 && touches(s.a2, m_dest, m_code);
    ce.d1   = (s.a1 == 0 && m_code >= 2) ? m_r0 : m_data;
    ce.d2   = (s.a2 == 0 && m_code >= 2) ? m_r0 : m_data;
    ce.err  = m_err;
    ce.code = m_code;
    ce.dest = m_dest;
    ce.data = m_data;
    ce.r0   = m_r0;
    cq.push_back(ce);
    if (s.rst) begin
      foreach (pend[r]) pend[r] = 0;
      m_err = 0; m_code = 0; m_dest = 0; m_data = 0; m_r0 = 0;
      inflight.delete();
    end else begin
      acc = s.iv && s.icode != 0 && !ce.full;
      for (int r = 0; r < 16; r++) begin
        n = pend[r] + int'(acc && touches(r, s.idest, s.icode)) - int'(touches(r, m_dest, m_code));
        if (n < 0) begin n = 0; m_err = 1; end
        if (n > 3) begin n = 3; m_err = 1; end
        pend[r] = n;
      end
      if (acc) inflight.push_back('{dest: s.idest, code: s.icode});
      if (s.mv && s.mcode != 0) begin
        m_code = 2'(s.mcode);
        m_dest = 4'(s.mdest);
        m_data = s.mtr ? s.ld : s.alu;
        m_r0   = s.rem;
        we = '{cyc: cyc + 1, code: m_code, dest: m_dest, data: m_data, r0: m_r0};
        wq.push_back(we);
      end else begin
        m_code = 0;
      end
    end
    @(posedge clk);
    #2;
  endtask

  // Monitor: combinational lookups and current WB outputs, mid-cycle
  always @(negedge clk) begin
    if (cq.size() > 0) begin
      comb_exp_t e;
      logic [75:0] act, req;
      e = cq.pop_front();
      act = {bus.out_issue_full, bus.out_op1_busy, bus.out_op2_busy, bus.out_op1_fwd,
             bus.out_op2_fwd, bus.out_sb_err, bus.out_fwd_data1, bus.out_fwd_data2,
             bus.out_cntrl_regwrite, bus.out_wr_addr, bus.out_data, bus.out_r0};
      req = {e.full, e.b1, e.b2, e.f1, e.f2, e.err, e.d1, e.d2, e.code, e.dest, e.data, e.r0};
      n_checks++;
      if (act !== req) begin
        n_err++;
        $display("FAIL lookup cyc=%0d full/b1/b2/f1/f2/err/d1/d2/rw/addr/data/r0 actual=%h required=%h",
                 cyc, act, req);
      end
    end
  end

  // Monitor: every register-file write must match the next queued expectation
  always begin
    @(posedge clk);
    #1;
    if (bus.out_cntrl_regwrite != 2'b00) begin
      n_checks++;
      if (wq.size() == 0 || wq[0].cyc != cyc) begin
        n_err++;
        $display("FAIL rf_write_unexpected cyc=%0d actual rw=%b required none", cyc, bus.out_cntrl_regwrite);
      end else begin
        wb_exp_t e;
        e = wq.pop_front();
        if ({bus.out_cntrl_regwrite, bus.out_wr_addr, bus.out_data, bus.out_r0} !==
            {e.code, e.dest, e.data, e.r0}) begin
          n_err++;
          $display("FAIL rf_write cyc=%0d actual rw=%b addr=%0d data=%h r0=%h required rw=%b addr=%0d data=%h r0=%h",
                   cyc, bus.out_cntrl_regwrite, bus.out_wr_addr, bus.out_data, bus.out_r0,
                   e.code, e.dest, e.data, e.r0);
        end
      end
    end else if (wq.size() > 0 && wq[0].cyc <= cyc) begin
      wb_exp_t e;
      e = wq.pop_front();
      n_checks++;
      n_err++;
      $display("FAIL rf_write_missing cyc=%0d actual rw=00 required rw=%b addr=%0d", cyc, e.code, e.dest);
    end
  end

  initial begin
    stim_t s;
    foreach (pend[r]) pend[r] = 0;
    m_err = 0; m_code = 0; m_dest = 0; m_data = 0; m_r0 = 0;
    @(posedge clk);
    #2;
    s = idle(); s.rst = 1;
    step(s); step(s);

    // Reset mid-flight leaves a stale MEM entry that underflows R4
    s = idle(); s.iv = 1; s.idest = 4; s.icode = 1; s.a1 = 4; step(s);
    s = idle(); s.rst = 1; s.a1 = 4; step(s);
    s = idle(); s.mv = 1; s.mdest = 4; s.mcode = 1; s.alu = 16'h1234; s.a1 = 4; step(s);
    s = idle(); s.a1 = 4; step(s);
    step(s);
    s = idle(); s.rst = 1; step(s);

    // Load path
    s = idle(); s.mv = 1; s.mdest = 6; s.mcode = 1; s.mtr = 1; s.ld = 16'h0024; s.alu = 16'hDEAD; step(s);
    s = idle(); step(s);

    // Division writes dest and R0; R0 forwards the remainder
    s = idle(); s.iv = 1; s.idest = 2; s.icode = 3; step(s);
    s = idle(); s.a1 = 0; s.a2 = 2; step(s);
    s = idle(); s.mv = 1; s.mdest = 2; s.mcode = 3; s.alu = 16'h00CC; s.rem = 16'h000F; s.a1 = 0; s.a2 = 2; step(s);
    s = idle(); s.a1 = 0; s.a2 = 2; step(s);
    step(s);

    // Saturation on R5, then an issue that coincides with a retire
    s = idle(); s.iv = 1; s.idest = 5; s.icode = 1; s.a1 = 5;
    repeat (4) step(s);
    s = idle(); s.mv = 1; s.mdest = 5; s.mcode = 1; s.alu = 16'h0005; s.a1 = 5; step(s);
    s = idle(); s.iv = 1; s.idest = 5; s.icode = 1; s.a1 = 5; step(s);
    s = idle(); s.mv = 1; s.mdest = 5; s.mcode = 1; s.alu = 16'h0055; s.a1 = 5;
    repeat (3) step(s);
    s = idle(); s.a1 = 5; step(s); step(s);

    // Forward only when the last pending write is in WB
    s = idle(); s.iv = 1; s.idest = 12; s.icode = 1; s.a2 = 12; step(s); step(s);
    s = idle(); s.mv = 1; s.mdest = 12; s.mcode = 1; s.alu = 16'h0110; s.a2 = 12; step(s);
    s = idle(); s.a2 = 12; step(s);
    s = idle(); s.mv = 1; s.mdest = 12; s.mcode = 1; s.alu = 16'h00AB; s.a2 = 12; step(s);
    s = idle(); s.a2 = 12; step(s); step(s);

    // Code 11 with dest 0 counts R0 once
    s = idle(); s.iv = 1; s.idest = 0; s.icode = 3; s.a1 = 0; step(s);
    s = idle(); s.a1 = 0; step(s);
    s = idle(); s.mv = 1; s.mdest = 0; s.mcode = 3; s.alu = 16'h7777; s.rem = 16'h0042; s.a1 = 0; step(s);
    s = idle(); s.a1 = 0; step(s); step(s);

    // Random traffic: in-order retirement of accepted issues, occasional stale entries and resets
    inflight.delete();
    for (int k = 0; k < 1500; k++) begin
      s = idle();
      s.rst   = ($urandom_range(0, 299) == 0);
      s.iv    = $urandom_range(0, 1);
      s.idest = $urandom_range(0, 15);
      s.icode = $urandom_range(0, 3);
      s.mtr   = $urandom_range(0, 1);
      s.alu   = 16'($urandom);
      s.ld    = 16'($urandom);
      s.rem   = 16'($urandom);
      s.a1    = $urandom_range(0, 15);
      s.a2    = (inflight.size() > 0 && $urandom_range(0, 1)) ? inflight[0].dest : $urandom_range(0, 15);
      if ($urandom_range(0, 79) == 0) begin
        s.mv = 1; s.mdest = $urandom_range(0, 15); s.mcode = $urandom_range(1, 3);
      end else if (inflight.size() > 0 && $urandom_range(0, 2) != 0) begin
        ifl_t f;
        f = inflight.pop_front();
        s.mv = 1; s.mdest = f.dest; s.mcode = f.code;
      end
      step(s);
    end
    s = idle();
    repeat (4) step(s);
    #10;
    n_checks++;
    if (wq.size() != 0 || cq.size() != 0) begin
      n_err++;
      $display("FAIL drain actual pending_writes=%0d pending_lookups=%0d required 0 0", wq.size(), cq.size());
    end
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
